game_seq: RTL and testbench

Game-flow sequencer for the Pacman design. It sits between the raw board inputs and the `graphic` renderer, alongside `vga_sync` inside `game_ctl`. It debounces the buttons, runs the top-level game state machine, and derives frame-locked movement ticks from `vsync`. It also owns the score and lives counters and pulses `level_reset` to reposition sprites, so `graphic` only draws and detects collisions.

---
 rtl/game_defs.sv | 35 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/game_seq.sv | 169 ++++++++++++++++
 tb/tb_game_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_defs.sv
// Shared definitions for the Pacman game: state codes, direction codes,
// button bit positions and the saturating score adder.
package game_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  localparam int BTN_W     = 5;

  // Add at 17 bits so the carry shows the overflow, then clamp.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a stability counter that only
// lets the output follow after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic db_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d = sync2_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/game_seq.sv
// Game-flow sequencer: debounced buttons, top-level game FSM, frame-locked
// move ticks, score/lives bookkeeping and the level_reset pulse for graphic.
module game_seq
  import game_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_DIV        = 4,
  parameter int DEATH_FRAMES    = 120,
  parameter int LIVES_INIT      = 3,
  parameter int PELLET_POINTS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  btn,
  input  logic        vsync,
  input  logic        pellet_eaten,
  input  logic        ghost_hit,
  input  logic        pellets_empty,
  output logic [2:0]  state,
  output logic [1:0]  dir,
  output logic        move_tick,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        level_reset
);

  localparam logic [3:0]  MOVE_LAST  = 4'(MOVE_DIV - 1);
  localparam logic [7:0]  DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [1:0]  LIVES_RST  = 2'(LIVES_INIT);
  localparam logic [15:0] POINTS     = 16'(PELLET_POINTS);

  logic [BTN_W-1:0] db;
  logic             start_prev_q, start_press;
  logic             vs_q, frame_q;

  game_state_e state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic        lr_q, lr_d;
  logic        mt_q, mt_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  dcnt_q, dcnt_d;

  for (genvar i = 0; i < BTN_W; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i  (clk),
      .rst_ni (reset),
      .btn_i  (btn[i]),
      .db_o   (db[i])
    );
  end

  assign start_press = db[BTN_START] & ~start_prev_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lives_d = lives_q;
    score_d = score_q;
    lr_d    = 1'b0;
    mt_d    = 1'b0;
    div_d   = div_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_RST;
          dir_d   = DIR_LEFT;
          lr_d    = 1'b1;
          div_d   = '0;
        end
      end
      ST_PLAY: begin
        if (pellet_eaten) score_d = sat_add(score_q, POINTS);
        case (db[BTN_RIGHT:BTN_UP])
          4'b0001: dir_d = DIR_UP;
          4'b0010: dir_d = DIR_DOWN;
          4'b0100: dir_d = DIR_LEFT;
          4'b1000: dir_d = DIR_RIGHT;
          default: dir_d = dir_q;
        endcase
        if (frame_q) begin
          if (div_q == MOVE_LAST) begin
            mt_d  = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 4'd1;
          end
        end
        if (ghost_hit) begin
          state_d = ST_DYING;
          dcnt_d  = '0;
        end else if (pellets_empty) begin
          state_d = ST_WIN;
        end else if (start_press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_press) begin
          state_d = ST_PLAY;
          div_d   = '0;
        end
      end
      ST_DYING: begin
        if (frame_q) begin
          if (dcnt_q == DEATH_LAST) begin
            dcnt_d = '0;
            if (lives_q == 2'd1) begin
              lives_d = '0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              lr_d    = 1'b1;
              state_d = ST_PLAY;
              div_d   = '0;
            end
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
      end
      ST_OVER, ST_WIN: begin
        if (start_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // vs_q/frame_q form the edge register: frame_q is one cycle per vsync fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev_q <= 1'b0;
      vs_q         <= 1'b0;
      frame_q      <= 1'b0;
      state_q      <= ST_IDLE;
      dir_q        <= DIR_LEFT;
      lives_q      <= LIVES_RST;
      score_q      <= '0;
      lr_q         <= 1'b0;
      mt_q         <= 1'b0;
      div_q        <= '0;
      dcnt_q       <= '0;
    end else begin
      start_prev_q <= db[BTN_START];
      vs_q         <= vsync;
      frame_q      <= vs_q & ~vsync;
      state_q      <= state_d;
      dir_q        <= dir_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      lr_q         <= lr_d;
      mt_q         <= mt_d;
      div_q        <= div_d;
      dcnt_q       <= dcnt_d;
    end
  end

  assign state       = state_q;
  assign dir         = dir_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level_reset = lr_q;
  assign move_tick   = mt_q;

endmodule

// File: tb/tb_game_seq.sv
// Scoreboard bench for game_seq: driver tasks push expected output events,
// a negedge monitor pops and compares whenever the outputs show an event.
module tb_game_seq;

  localparam int DEB   = 4;
  localparam int MDIV  = 2;
  localparam int DFR   = 3;
  localparam int LINIT = 3;
  localparam int PTS   = 10;
  localparam int W     = 57;

  // clock / reset
  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic reset = 1'b0;
  int   cyc = 0;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  btn = '0;
  logic        vsync = 1'b1;
  logic        pellet_eaten = 1'b0;
  logic        ghost_hit = 1'b0;
  logic        pellets_empty = 1'b0;
  logic [2:0]  state;
  logic [1:0]  dir;
  logic        move_tick;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        level_reset;

  game_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .MOVE_DIV        (MDIV),
    .DEATH_FRAMES    (DFR),
    .LIVES_INIT      (LINIT),
    .PELLET_POINTS   (PTS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .vsync         (vsync),
    .pellet_eaten  (pellet_eaten),
    .ghost_hit     (ghost_hit),
    .pellets_empty (pellets_empty),
    .state         (state),
    .dir           (dir),
    .move_tick     (move_tick),
    .lives         (lives),
    .score         (score),
    .level_reset   (level_reset)
  );

  // reference model of the game rules (0 idle,1 play,2 pause,3 dying,4 over,5 win)
  int m_state, m_dir, m_lives, m_score, m_frames, m_dframes;
  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  // event word: {cycle, state, dir, lives, score, level_reset, move_tick}
  function automatic logic [W-1:0] mk(int c, logic lr, logic mt);
    return {32'(c), 3'(m_state), 2'(m_dir), 2'(m_lives), 16'(m_score), lr, mt};
  endfunction

  task automatic expect_at(int c, logic lr, logic mt);
    exp_q.push_back(mk(c, lr, mt));
  endtask

  task automatic model_reset();
    m_state = 0; m_dir = 2; m_lives = LINIT; m_score = 0;
    m_frames = 0; m_dframes = 0;
  endtask

  task automatic add_points();
    m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
  endtask

  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_state", state, 0);
    chk("rst_dir", dir, 2);
    chk("rst_lives", lives, LINIT);
    chk("rst_score", score, 0);
    chk("rst_level_reset", level_reset, 0);
    chk("rst_move_tick", move_tick, 0);
  endtask

  // driver tasks
  task automatic press(logic [4:0] mask, int hold);
    int k, nd;
    @(posedge clk); #1;
    btn = btn | mask;
    k = cyc;
    if (mask[4]) begin
      case (m_state)
        0: begin
          m_state = 1; m_frames = 0; m_score = 0; m_lives = LINIT; m_dir = 2;
          expect_at(k + DEB + 3, 1'b1, 1'b0);
        end
        1: begin m_state = 2; expect_at(k + DEB + 3, 1'b0, 1'b0); end
        2: begin m_state = 1; m_frames = 0; expect_at(k + DEB + 3, 1'b0, 1'b0); end
        4, 5: begin m_state = 0; expect_at(k + DEB + 3, 1'b0, 1'b0); end
        default: ;
      endcase
    end else if (m_state == 1 && $countones(mask) == 1) begin
      nd = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) nd = i;
      if (nd != m_dir) begin
        m_dir = nd;
        expect_at(k + DEB + 3, 1'b0, 1'b0);
      end
    end
    repeat (hold) @(posedge clk);
    #1;
    btn = btn & ~mask;
    repeat (DEB + 8 + $urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic frame();
    int k;
    @(posedge clk); #1;
    vsync = 1'b0;
    k = cyc;
    if (m_state == 1) begin
      m_frames++;
      if (m_frames % MDIV == 0) expect_at(k + 2, 1'b0, 1'b1);
    end else if (m_state == 3) begin
      m_dframes++;
      if (m_dframes == DFR) begin
        if (m_lives == 1) begin
          m_lives = 0; m_state = 4;
          expect_at(k + 2, 1'b0, 1'b0);
        end else begin
          m_lives--; m_state = 1; m_frames = 0;
          expect_at(k + 2, 1'b1, 1'b0);
        end
      end
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    vsync = 1'b1;
    repeat ($urandom_range(3, 6)) @(posedge clk);
  endtask

  task automatic pellets(int n);
    int prev;
    @(posedge clk); #1;
    pellet_eaten = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (m_state == 1) begin
        prev = m_score;
        add_points();
        if (m_score != prev) expect_at(cyc + 1, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
    end
    pellet_eaten = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  task automatic ghost(logic pel, logic emp);
    int k;
    @(posedge clk); #1;
    ghost_hit = 1'b1; pellet_eaten = pel; pellets_empty = emp;
    k = cyc;
    if (m_state == 1) begin
      if (pel) add_points();
      m_state = 3; m_dframes = 0;
      expect_at(k + 1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    ghost_hit = 1'b0; pellet_eaten = 1'b0; pellets_empty = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic win();
    int k;
    @(posedge clk); #1;
    pellets_empty = 1'b1;
    k = cyc;
    if (m_state == 1) begin
      m_state = 5;
      expect_at(k + 1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    pellets_empty = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // scoreboard monitor
  localparam logic [22:0] RST_SLOW = {3'd0, 2'd2, 2'(LINIT), 16'd0};
  logic [22:0] prev_slow;

  always @(negedge clk or negedge reset) begin
    logic [22:0]  cur;
    logic [W-1:0] got, e;
    if (!reset) begin
      prev_slow = RST_SLOW;
    end else begin
      cur = {state, dir, lives, score};
      while (exp_q.size() > 0 && int'(exp_q[0][W-1:25]) < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        errors++;
        $display("FAIL missing_event exp=%h seen_by_cycle=%0d", e, cyc);
      end
      if (cur != prev_slow || level_reset || move_tick) begin
        got = {32'(cyc), cur, level_reset, move_tick};
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL event got=%h exp=%h", got, e);
          end
        end
      end
      prev_slow = cur;
    end
  end

  // stimulus sequence
  initial begin
    int b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // bounce shorter than the debounce window, then a stable press
    @(posedge clk); #1;
    btn[4] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn[4] = 1'b0;
    repeat (3) @(posedge clk);
    press(5'b10000, 10);

    // direction: single buttons update, two together hold
    press(5'b01000, 10);
    repeat (4) begin
      b = $urandom_range(0, 3);
      press(5'(1 << b), 10);
    end
    press(5'b00101, 10);

    // ticks in play, then pause (no ticks, events ignored), then resume
    repeat (7) frame();
    press(5'b10000, 10);
    repeat (4) frame();
    pellets(1);
    ghost(1'b0, 1'b0);
    press(5'b10000, 10);
    repeat (2) frame();

    // scoring
    repeat (3) pellets(1);

    // same-cycle ghost, pellet, empty: dying wins and the pellet still scores
    ghost(1'b1, 1'b1);
    repeat (DFR) frame();

    // drive the score up to the saturation boundary
    pellets((65530 - m_score) / PTS);
    pellets(1);
    pellets(2);

    // remaining deaths down to game over
    ghost(1'b0, 1'b0);
    repeat (DFR) frame();
    ghost(1'b0, 1'b0);
    repeat (DFR) frame();

    // over -> idle -> play -> win -> idle -> play -> dying
    press(5'b10000, 10);
    press(5'b10000, 10);
    win();
    press(5'b10000, 10);
    press(5'b10000, 10);
    ghost(1'b0, 1'b0);
    frame();

    // asynchronous reset with the clock stopped
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    #5;
    reset = 1'b1;
    #5;
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    press(5'b10000, 10);
    repeat (10) @(posedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
